sobel_filter: RTL and testbench

Pipelined 3x3 Sobel edge-magnitude operator for the image-processing datapath. It takes one 3x3 pixel window per cycle and computes horizontal and vertical gradients. It emits an 8-bit edge strength two cycles later. It sits between the line-buffer/window generator and the downstream thresholding/output stage.

---
 rtl/sobel_filter_if.sv | 23 ++
 rtl/sobel_filter.sv | 78 +++++++
 tb/tb_sobel_filter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sobel_filter_if.sv
// Window/result bundle between the window generator, the Sobel operator and the threshold stage.
// Carries one 3x3 window per cycle in, one 8-bit edge strength per cycle out.
// No backpressure: the producer only qualifies data with in_valid.
interface sobel_filter_if;
  logic       in_valid;
  logic [8:0] in0, in1, in2;
  logic [8:0] in3, in4, in5;
  logic [8:0] in6, in7, in8;
  logic       out_valid;
  logic [7:0] out0;

  // Producer side: drives the window, observes the result.
  modport master (
    output in_valid, in0, in1, in2, in3, in4, in5, in6, in7, in8,
    input  out_valid, out0
  );

  // Operator side: consumes the window, drives the result.
  modport slave (
    input  in_valid, in0, in1, in2, in3, in4, in5, in6, in7, in8,
    output out_valid, out0
  );
endinterface

// File: rtl/sobel_filter.sv
// Sobel 3x3 edge magnitude: |Gx| + |Gy| mapped to 8 bits (SOBEL_SATURATE_EN: clamp, else mag/16).
// Latency 2 cycles from in_valid to out_valid, throughput one window per cycle.
// No backpressure: every valid window is accepted; invalid cycles travel as bubbles.
module sobel_filter (
  input  logic         clk,
  input  logic         rst_n,
  sobel_filter_if.slave bus
);

  // Stage 1 next-state: gradients from the six border pixels of each axis.
  logic [11:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [11:0] gx_d, gy_d;
  logic signed [11:0] gx_q, gy_q;
  logic               vld1_q;

  // Stage 2 next-state: magnitude and output mapping.
  logic [11:0] abs_x, abs_y, mag;
  logic [7:0]  out0_d, out0_q;
  logic        out_vld_q;

  // Weighted column/row sums; each side peaks at 2044, so 12-bit signed never overflows.
  always_comb begin
    gx_pos = 12'(bus.in2) + {2'b00, bus.in5, 1'b0} + 12'(bus.in8);
    gx_neg = 12'(bus.in0) + {2'b00, bus.in3, 1'b0} + 12'(bus.in6);
    gy_pos = 12'(bus.in6) + {2'b00, bus.in7, 1'b0} + 12'(bus.in8);
    gy_neg = 12'(bus.in0) + {2'b00, bus.in1, 1'b0} + 12'(bus.in2);
    gx_d   = $signed(gx_pos - gx_neg);
    gy_d   = $signed(gy_pos - gy_neg);
  end

  // Stage 1 registers: gradients update every cycle, the valid flag qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q   <= '0;
      gy_q   <= '0;
      vld1_q <= 1'b0;
    end else begin
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      vld1_q <= bus.in_valid;
    end
  end

  // Absolute values (|G| <= 2044 so negation cannot wrap) and the build-selected 8-bit mapping.
  always_comb begin
    abs_x = gx_q[11] ? 12'(-gx_q) : 12'(gx_q);
    abs_y = gy_q[11] ? 12'(-gy_q) : 12'(gy_q);
    mag   = abs_x + abs_y;
`ifdef SOBEL_SATURATE_EN
    out0_d = (mag > 12'd255) ? 8'hFF : mag[7:0];
`else
    out0_d = mag[11:4];
`endif
  end

  // Stage 2 registers: final result and its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q    <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out0_q    <= out0_d;
      out_vld_q <= vld1_q;
    end
  end

  assign bus.out0      = out0_q;
  assign bus.out_valid = out_vld_q;

  // The centre pixel never contributes; the linear build also drops the magnitude's low nibble.
  logic unused_bits;
`ifdef SOBEL_SATURATE_EN
  assign unused_bits = ^bus.in4;
`else
  assign unused_bits = ^{bus.in4, mag[3:0]};
`endif

endmodule

// File: tb/tb_sobel_filter.sv
// Bench for sobel_filter: directed test-plan windows, a randomized stream and a mid-flight reset.
// Expected results come from a plain-arithmetic Sobel model; each result is due one step later.
// Inputs change #1 after a rising edge; outputs are checked at the same point.
module tb_sobel_filter;

  logic clk;
  logic rst_n;
  sobel_filter_if bus ();

  sobel_filter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  int n_tests = 0;
  int n_fail  = 0;
  int win [9];
  bit pend_vld;
  int pend_val;

  // Reference: Sobel from the textbook definition using plain integer arithmetic.
  function automatic int model(input int p0, p1, p2, p3, p5, p6, p7, p8);
    int gx, gy, mag;
    gx  = (p2 + 2 * p5 + p8) - (p0 + 2 * p3 + p6);
    gy  = (p6 + 2 * p7 + p8) - (p0 + 2 * p1 + p2);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_SATURATE_EN
    return (mag > 255) ? 255 : mag;
`else
    return mag / 16;
`endif
  endfunction

  task automatic chk(input int got, input int want, input string tag);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 9; i++) win[i] = v;
  endtask

  // One clock step: present a window, take the edge, check what the previous step predicted.
  task automatic step(input bit v, input string tag);
    bus.in_valid = v;
    bus.in0 = 9'(win[0]); bus.in1 = 9'(win[1]); bus.in2 = 9'(win[2]);
    bus.in3 = 9'(win[3]); bus.in4 = 9'(win[4]); bus.in5 = 9'(win[5]);
    bus.in6 = 9'(win[6]); bus.in7 = 9'(win[7]); bus.in8 = 9'(win[8]);
    @(posedge clk);
    #1;
    chk(int'(bus.out_valid), int'(pend_vld), {tag, "_vld"});
    if (pend_vld) chk(int'(bus.out0), pend_val, {tag, "_out0"});
    pend_vld = v;
    pend_val = model(win[0], win[1], win[2], win[3], win[5], win[6], win[7], win[8]);
  endtask

  initial begin
    rst_n    = 1'b0;
    pend_vld = 1'b0;
    pend_val = 0;
    set_all(0);
    bus.in_valid = 1'b0;
    bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0; bus.in4 = '0;
    bus.in5 = '0; bus.in6 = '0; bus.in7 = '0; bus.in8 = '0;
    #1;
    chk(int'(bus.out_valid), 0, "reset_vld");
    chk(int'(bus.out0), 0, "reset_out0");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, "idle0");
    step(1'b0, "idle1");

    // Test-plan windows, each followed by a bubble so out_valid must pulse for one cycle.
    set_all(0);                                        step(1'b1, "zeros");
    step(1'b0, "zeros_gap");
    set_all(200);                                      step(1'b1, "uniform200");
    step(1'b0, "uniform_gap");
    set_all(0); win[2] = 10;                           step(1'b1, "single10");
    step(1'b0, "single_gap");
    set_all(0); win[2] = 100; win[5] = 100; win[8] = 100; step(1'b1, "vedge100");
    step(1'b0, "vedge_gap");
    set_all(0); win[2] = 511; win[5] = 511; win[8] = 511; step(1'b1, "vedge511");
    step(1'b0, "max_gap");

    // Three distinct windows back to back.
    set_all(0); win[6] = 300; win[7] = 300; win[8] = 300; step(1'b1, "burst_a");
    set_all(0); win[0] = 511; win[1] = 511; win[3] = 511; step(1'b1, "burst_b");
    set_all(7); win[2] = 90;  win[7] = 400;               step(1'b1, "burst_c");
    set_all(0);
    step(1'b0, "burst_d");
    step(1'b0, "burst_e");

    // Randomized stream with bubbles, occasionally extreme pixels.
    for (int i = 0; i < 80; i++) begin
      for (int j = 0; j < 9; j++) begin
        case ($urandom_range(0, 5))
          0:       win[j] = 0;
          1:       win[j] = 511;
          default: win[j] = int'($urandom_range(0, 511));
        endcase
      end
      step($urandom_range(0, 3) != 0, "rand");
    end
    set_all(0);
    step(1'b0, "rand_flush0");
    step(1'b0, "rand_flush1");

    // Reset with two windows in flight: output drops at once and neither result emerges later.
    set_all(0); win[2] = 511; win[5] = 511;  step(1'b1, "pre_rst_a");
    set_all(0); win[6] = 250; win[7] = 250;  step(1'b1, "pre_rst_b");
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk(int'(bus.out_valid), 0, "midrst_vld");
    chk(int'(bus.out0), 0, "midrst_out0");
    pend_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_all(0);
    for (int i = 0; i < 4; i++) step(1'b0, "post_rst");
    set_all(0); win[2] = 10;                 step(1'b1, "post_rst_live");
    set_all(0);
    step(1'b0, "post_rst_out");
    step(1'b0, "post_rst_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
